step_conditioner: RTL
=====================

# step_conditioner

Input-conditioning stage that sits directly upstream of the step-driven sequence FSM. It synchronizes a raw board push-button/switch to `clk` and generates the divided tick that gates FSM state updates. It debounces the input on that tick and emits a clean level plus a single-cycle rising-edge pulse. The FSM consumes `level` as its data input and `tick` as its state-update enable, so every advance is one clean, debounced step.

## Interface
- `DIV`, 50_000: tick period in `clk` cycles; legal range ≥2.
- `STABLE`, 4: consecutive equal tick-samples required to accept a new level; legal range ≥2.
- `REPEAT`, 8: ticks between repeated `rise` pulses while held; used only with `STEP_AUTO_REPEAT_EN`.
- `clk`  input  1  system clock; the block's only clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `raw`  input  1  asynchronous button/switch input, bouncing.
- `tick`  output  1  one-`clk` pulse every `DIV` cycles; state-update enable for the downstream FSM.
- `level`  output  1  debounced level of `raw`.
- `rise`  output  1  one-`clk` pulse on accepted 0→1 transition of `level`.

## Operation
- Synchronizer: two flops, `raw`→`s1`→`s0`. Only `s0` is used downstream.
- Tick divider: `div_cnt` counts 0..DIV-1 and wraps to 0. `tick` = (`div_cnt`==DIV-1), registered so that it is high exactly one cycle per period.
- Debounce FSM, evaluated only on cycles with `tick`=1; on other cycles it holds state. It has four states and a sample counter `cnt`, width clog2(STABLE)+1:
  - IDLE (`level`=0): `s0`=1 → ARM1, `cnt`=1; else stay.
  - ARM1: `s0`=0 → IDLE, `cnt`=0. `s0`=1 and `cnt`==STABLE-1 → HIGH, `cnt`=0, set `level`=1, pulse `rise`. Otherwise `s0`=1 → `cnt`+1.
  - HIGH (`level`=1): `s0`=0 → ARM0, `cnt`=1; else stay.
  - ARM0: `s0`=1 → HIGH, `cnt`=0. `s0`=0 and `cnt`==STABLE-1 → IDLE, `cnt`=0, clear `level`. Otherwise `s0`=0 → `cnt`+1.
- Any single contrary tick-sample aborts an ARM state back to the originating stable state. Bounce shorter than STABLE ticks is therefore never visible on the outputs.
- `rise` fires only on the IDLE/ARM1→HIGH acceptance. There is no output pulse for the falling edge.

## Timing
- Reset values: `tick`=0, `level`=0, `rise`=0, FSM=IDLE, `cnt`=0, `div_cnt`=0, `s1`=`s0`=0.
- `level` and `rise` are registered. They change in the cycle after the tick cycle that accepted the STABLE-th sample.
- Worst-case latency from a clean `raw` edge to `level`: 2 + STABLE·DIV cycles. Best case: 2 + (STABLE-1)·DIV + 1 cycles.
- `rise` coincides with the first cycle of `level`=1 and lasts exactly one cycle. It never coincides with `tick`.
- Reset asserted mid-ARM or mid-HIGH: all state clears immediately. After release, `level` stays 0 until a full STABLE acceptance; no `rise` is produced for a button already held through reset until it is accepted anew.
- `div_cnt` wraps silently; it is not affected by FSM state.

## Configuration
- `STEP_AUTO_REPEAT_EN` defined: adds a repeat counter `rpt` that clears on entry to HIGH. While in HIGH, `rpt` increments per tick. When `rpt` reaches REPEAT-1, it resets to 0 and emits a further one-cycle `rise` on the next cycle. ARM0 freezes `rpt`; an abort back to HIGH resumes it.
- `STEP_AUTO_REPEAT_EN` undefined: no `rpt` logic. Exactly one `rise` per accepted press regardless of hold time.

## Test plan
Use DIV=4, STABLE=3, REPEAT=2 unless noted.
- Reset, `raw`=0 for 40 cycles → `tick` pulses every 4 cycles; `level`=0 and `rise`=0 throughout.
- `raw`=1 held from a tick boundary → `level` rises after 3 sampling ticks (≤14 cycles); `rise` high for exactly 1 cycle; no further `rise` while held (macro undefined).
- `raw` toggling 1,0 every 5 cycles for 40 cycles, then steady 1 → no `level` change during the toggling; a single `rise` after the steady 3-tick acceptance.
- Level 1 accepted, then `raw`=0 for 1 tick and back to 1 → FSM goes HIGH→ARM0→HIGH; `level` stays 1; no `rise`.
- `rst` pulsed low while in ARM1 with `cnt`=2 → outputs 0 immediately; re-acceptance requires a full 3 ticks after release.
- `STEP_AUTO_REPEAT_EN` defined, `raw` held 1 for 10 ticks after acceptance → initial `rise`, then a `rise` every 2 ticks (5 extra pulses); none after release.

Source files
------------

// File: rtl/step_conditioner.sv
// step_conditioner: synchronizes and debounces a raw button on a divided tick, emitting level, rise and tick.
// Define STEP_AUTO_REPEAT_EN to re-pulse rise every REPEAT ticks while the button stays held.
module step_conditioner #(
  parameter int DIV    = 50_000,
  parameter int STABLE = 4,
  parameter int REPEAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic tick,
  output logic level,
  output logic rise
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(STABLE) + 1;
  typedef enum logic [1:0] {IDLE, ARM1, HIGH, ARM0} state_t;
  if (DIV < 2 || STABLE < 2 || REPEAT < 1) begin : g_bad_param
    $error("step_conditioner: DIV and STABLE must be >= 2, REPEAT >= 1");
  end
  logic s1_q, s0_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic tick_q, tick_d;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d;
`ifdef STEP_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT) + 1;
  logic [RW-1:0] rpt_q, rpt_d;
`endif
  always_comb begin
    div_cnt_d = (div_cnt_q == DW'(DIV - 1)) ? '0 : div_cnt_q + 1'b1;
    tick_d = (div_cnt_q == DW'(DIV - 1));
    state_d = state_q;
    cnt_d = cnt_q;
    level_d = level_q;
    rise_d = 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
    rpt_d = rpt_q;
`endif
    if (tick_q) begin
      case (state_q)
        IDLE: if (s0_q) begin
          state_d = ARM1;
          cnt_d = CW'(1);
        end
        ARM1: if (!s0_q) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (cnt_q == CW'(STABLE - 1)) begin
          state_d = HIGH;
          cnt_d = '0;
          level_d = 1'b1;
          rise_d = 1'b1;
`ifdef STEP_AUTO_REPEAT_EN
          rpt_d = '0;
`endif
        end else cnt_d = cnt_q + 1'b1;
        HIGH: if (!s0_q) begin
          state_d = ARM0;
          cnt_d = CW'(1);
        end else begin
`ifdef STEP_AUTO_REPEAT_EN
          rise_d = (rpt_q == RW'(REPEAT - 1));
          rpt_d = (rpt_q == RW'(REPEAT - 1)) ? '0 : rpt_q + 1'b1;
`endif
        end
        ARM0: if (s0_q) begin
          state_d = HIGH;
          cnt_d = '0;
        end else if (cnt_q == CW'(STABLE - 1)) begin
          state_d = IDLE;
          cnt_d = '0;
          level_d = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s0_q <= 1'b0;
      div_cnt_q <= '0;
      tick_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
      rpt_q <= '0;
`endif
    end else begin
      s1_q <= raw;
      s0_q <= s1_q;
      div_cnt_q <= div_cnt_d;
      tick_q <= tick_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= rise_d;
`ifdef STEP_AUTO_REPEAT_EN
      rpt_q <= rpt_d;
`endif
    end
  end
  assign tick = tick_q;
  assign level = level_q;
  assign rise = rise_q;
endmodule
